// File: rtl/usb_pio_pkg.sv
// Shared constants for the USB control-line PIO: register map, capture modes
// and the Avalon data bus width.
package usb_pio_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/usb_pio_if.sv
// Avalon-MM slave bus bundle for the PIO register file.
interface usb_pio_if;
    import usb_pio_pkg::*;

    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [BUS_W-1:0] writedata;
    logic [BUS_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/usb_pio_sync.sv
// Pin input synchroniser, previous-value flop, post-reset warm-up counter
// and per-bit edge detection.
module usb_pio_sync
    import usb_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_det
);

    // Detection stays off until the whole chain plus prev hold real pin data.
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;
    logic [WIDTH-1:0]                  prev;
    logic [2:0]                        warm;
    logic [WIDTH-1:0]                  raw_edge;

    // Shift the asynchronous pins through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_in = stage[SYNC_STAGES-1];

    // Hold last cycle's synchronised value for edge comparison.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= sync_in;
        end
    end

    // Saturating warm-up counter started at reset release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            warm <= '0;
        end else if (warm != WARM_DONE) begin
            warm <= warm + 3'd1;
        end
    end

    // Select the edge polarity fixed at elaboration.
    always_comb begin
        raw_edge = '0;
        case (EDGE_TYPE)
            EDGE_RISE: raw_edge = sync_in & ~prev;
            EDGE_FALL: raw_edge = ~sync_in & prev;
            default:   raw_edge = sync_in ^ prev;
        endcase
    end

    assign edge_det = (warm == WARM_DONE) ? raw_edge : '0;

endmodule

// File: rtl/usb_pio_ctrl.sv
// Avalon-MM PIO for USB strobe/select/status lines: per-bit direction,
// atomic set/clear, synchronised input, edge capture and maskable irq.
module usb_pio_ctrl
    import usb_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    usb_pio_if.slave         bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_word;
    logic             wr;
    logic             unused_wdata;

    // Bus bits above WIDTH carry no meaning for this port.
    assign unused_wdata = ^bus.writedata;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign wr           = bus.chipselect && !bus.write_n;
    assign cap_clr      = (wr && bus.address == ADDR_EDGE_CAP) ? wdata : '0;

    usb_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync_in  (sync_in),
        .edge_det (edge_det)
    );

    // Output data register with direct, set and clear write paths.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:   data_out <= wdata;
                ADDR_OUTSET: data_out <= data_out | wdata;
                ADDR_OUTCLR: data_out <= data_out & ~wdata;
                default:     data_out <= data_out;
            endcase
        end
    end

    // Direction and interrupt mask registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dir      <= DIR_RESET;
            irq_mask <= '0;
        end else if (wr) begin
            if (bus.address == ADDR_DIR) begin
                dir <= wdata;
            end
            if (bus.address == ADDR_IRQ_MASK) begin
                irq_mask <= wdata;
            end
        end
    end

    // Sticky edge capture; a fresh edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | edge_det;
        end
    end

    // Zero-wait-state read mux; inputs shown where dir=0, outputs where dir=1.
    always_comb begin
        rd_word = '0;
        case (bus.address)
            ADDR_DATA:     rd_word = (sync_in & ~dir) | (data_out & dir);
            ADDR_DIR:      rd_word = dir;
            ADDR_IRQ_MASK: rd_word = irq_mask;
            ADDR_EDGE_CAP: rd_word = edge_cap;
            default:       rd_word = '0;
        endcase
    end

    assign bus.readdata = BUS_W'(rd_word);
    assign out_port     = data_out;
    assign out_en       = dir;
    assign irq          = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_usb_pio_ctrl.sv
// Bench for usb_pio_ctrl: a rising-edge instance and an any-edge instance
// share clock, reset, pins and bus stimulus; both are compared against a
// behavioural register/pin-delay model.
module tb_usb_pio_ctrl;

    localparam int SS = 2;

    logic        clk;
    logic        reset_n;
    logic [7:0]  pins;
    logic [2:0]  b_addr;
    logic        b_cs;
    logic        b_wn;
    logic [31:0] b_wd;

    logic [7:0]  out0, en0, out1, en1;
    logic        irq0, irq1;

    usb_pio_if bus0 ();
    usb_pio_if bus1 ();

    assign bus0.address    = b_addr;
    assign bus0.chipselect = b_cs;
    assign bus0.write_n    = b_wn;
    assign bus0.writedata  = b_wd;
    assign bus1.address    = b_addr;
    assign bus1.chipselect = b_cs;
    assign bus1.write_n    = b_wn;
    assign bus1.writedata  = b_wd;

    usb_pio_ctrl #(
        .WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hFF),
        .EDGE_TYPE(0), .SYNC_STAGES(SS)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(pins),
        .out_port(out0), .out_en(en0), .irq(irq0)
    );

    usb_pio_ctrl #(
        .WIDTH(8), .RESET_VALUE(8'h00), .DIR_RESET(8'h00),
        .EDGE_TYPE(2), .SYNC_STAGES(SS)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port(pins),
        .out_port(out1), .out_en(en1), .irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (index 0 = rising instance, 1 = any-edge instance)
    logic [7:0] m_data [2];
    logic [7:0] m_dir  [2];
    logic [7:0] m_mask [2];
    logic [7:0] m_cap  [2];
    logic [7:0] hist   [8];   // hist[k] = pin value captured k edges ago
    int         since_rel;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int d, input logic [2:0] a);
        logic [7:0] s;
        s = hist[SS-1];
        case (a)
            3'd0:    return {24'd0, (s & ~m_dir[d]) | (m_data[d] & m_dir[d])};
            3'd1:    return {24'd0, m_dir[d]};
            3'd2:    return {24'd0, m_mask[d]};
            3'd3:    return {24'd0, m_cap[d]};
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_step();
        logic [7:0] s, p, ev, clr, wd;
        if (!reset_n) begin
            m_data[0] = 8'hA5; m_dir[0] = 8'hFF;
            m_data[1] = 8'h00; m_dir[1] = 8'h00;
            for (int d = 0; d < 2; d++) begin
                m_mask[d] = 8'h00;
                m_cap[d]  = 8'h00;
            end
            for (int k = 0; k < 8; k++) hist[k] = 8'h00;
            since_rel = 0;
        end else begin
            if (since_rel < 1000) since_rel++;
            s  = hist[SS-1];
            p  = hist[SS];
            wd = b_wd[7:0];
            for (int d = 0; d < 2; d++) begin
                ev = 8'h00;
                if (since_rel >= SS + 2) ev = (d == 0) ? (s & ~p) : (s ^ p);
                clr = 8'h00;
                if (b_cs && !b_wn) begin
                    case (b_addr)
                        3'd0: m_data[d] = wd;
                        3'd1: m_dir[d]  = wd;
                        3'd2: m_mask[d] = wd;
                        3'd3: clr       = wd;
                        3'd4: m_data[d] = m_data[d] | wd;
                        3'd5: m_data[d] = m_data[d] & ~wd;
                        default: ;
                    endcase
                end
                m_cap[d] = (m_cap[d] & ~clr) | ev;
            end
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pins;
        end
    endtask

    task automatic check_all();
        check("out_port0", {24'd0, out0}, {24'd0, m_data[0]});
        check("out_en0",   {24'd0, en0},  {24'd0, m_dir[0]});
        check("irq0",      {31'd0, irq0}, {31'd0, |(m_cap[0] & m_mask[0])});
        check("readdata0", bus0.readdata, exp_rd(0, b_addr));
        check("out_port1", {24'd0, out1}, {24'd0, m_data[1]});
        check("out_en1",   {24'd0, en1},  {24'd0, m_dir[1]});
        check("irq1",      {31'd0, irq1}, {31'd0, |(m_cap[1] & m_mask[1])});
        check("readdata1", bus1.readdata, exp_rd(1, b_addr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step();
        tick();
        #1;
        check_all();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        b_addr = a; b_cs = 1'b1; b_wn = 1'b0; b_wd = d;
        tick();
        b_cs = 1'b0; b_wn = 1'b1;
        #1;
        check_all();
    endtask

    task automatic read0(input logic [2:0] a, input logic [7:0] e, input string tag);
        b_addr = a; b_cs = 1'b1;
        #1;
        check(tag, bus0.readdata, {24'd0, e});
        b_cs = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; pins = 8'h00;
        b_addr = 3'd0; b_cs = 1'b0; b_wn = 1'b1; b_wd = 32'd0;
        since_rel = 0;
        step(); step();
        check("rst_out_port", {24'd0, out0}, 32'h0000_00A5);
        check("rst_out_en",   {24'd0, en0},  32'h0000_00FF);
        check("rst_irq",      {31'd0, irq0}, 32'd0);
        read0(3'd3, 8'h00, "rst_edge_cap");

        reset_n = 1'b1;
        bus_write(3'd0, 32'h3C);
        check("data_write", {24'd0, out0}, 32'h3C);
        bus_write(3'd4, 32'h01);
        check("outset", {24'd0, out0}, 32'h3D);
        bus_write(3'd5, 32'h0C);
        check("outclr", {24'd0, out0}, 32'h31);
        bus_write(3'd6, 32'hFFFF_FFFF);
        check("reserved_wr", {24'd0, out0}, 32'h31);
        read0(3'd6, 8'h00, "reserved_rd");

        // Mixed-direction read-back with input synchroniser latency
        bus_write(3'd1, 32'h0F);
        bus_write(3'd0, 32'h05);
        pins = 8'hA0;
        step();
        read0(3'd0, 8'h05, "sync_early");
        step();
        read0(3'd0, 8'hA5, "sync_late");
        step(); step();
        bus_write(3'd3, 32'hFF);
        read0(3'd3, 8'h00, "w1c_all");

        // Rising capture latency, falling ignored, clear drops irq
        bus_write(3'd2, 32'h02);
        pins = 8'hA2;
        step();
        check("irq_lat1", {31'd0, irq0}, 32'd0);
        step();
        check("irq_lat2", {31'd0, irq0}, 32'd0);
        step();
        check("irq_lat3", {31'd0, irq0}, 32'd1);
        read0(3'd3, 8'h02, "cap_rise");
        pins = 8'hA0;
        step(); step(); step(); step();
        read0(3'd3, 8'h02, "fall_ignored");
        bus_write(3'd3, 32'h02);
        check("irq_cleared", {31'd0, irq0}, 32'd0);

        // Edge and clear of the same bit in the same cycle
        pins = 8'hA2;
        step(); step();
        bus_write(3'd3, 32'h02);
        check("set_beats_clr", {31'd0, irq0}, 32'd1);
        read0(3'd3, 8'h02, "set_beats_clr_cap");

        // Pins high through reset release must not capture
        pins = 8'hFF;
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        b_addr = 3'd3; b_cs = 1'b1; #1;
        check("warmup_any", bus1.readdata, 32'd0);
        b_cs = 1'b0;
        pins = 8'h00;
        step(); step(); step();
        b_addr = 3'd3; b_cs = 1'b1; #1;
        check("any_fall", bus1.readdata, 32'hFF);
        b_cs = 1'b0;
        reset_n = 1'b0;
        step();
        b_addr = 3'd3; b_cs = 1'b1; #1;
        check("midrst_cap", bus1.readdata, 32'd0);
        check("midrst_out", {24'd0, out0}, 32'hA5);
        b_cs = 1'b0;
        reset_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
            else if ($urandom_range(0, 3) == 0) pins = pins ^ (8'h1 << $urandom_range(0, 7));
            reset_n = ($urandom_range(0, 150) != 0);
            b_addr  = 3'($urandom_range(0, 7));
            b_wd    = $urandom;
            case ($urandom_range(0, 3))
                0:       begin b_cs = 1'b1; b_wn = 1'b0; end
                1:       begin b_cs = 1'b0; b_wn = 1'b0; end
                default: begin b_cs = 1'b1; b_wn = 1'b1; end
            endcase
            #1;
            check_all();
            step();
        end
        reset_n = 1'b1; b_cs = 1'b0; b_wn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_pio_ctrl.md
# usb_pio_ctrl

Parametrised Avalon-MM slave PIO: the next generation of the single-bit USB control-line output ports. Provides up to 32 bidirectional lines with per-bit direction, atomic set/clear writes, synchronised input sampling, edge capture and a maskable level interrupt. Sits on the system Avalon bus beside the USB controller and drives or samples USB strobe, select and status lines.

## Interface
- WIDTH, 8: number of I/O lines, 1..32.
- RESET_VALUE, 0: reset value of the output data register, WIDTH bits.
- DIR_RESET, 0: reset value of the direction register, WIDTH bits; 1 = output.
- EDGE_TYPE, 0: capture mode; 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2: input synchroniser depth, 2..3.

- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  read data; combinational, zero wait states; bits above WIDTH are 0.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- out_en  out  WIDTH  direction register; drives the pad tristate enable.
- irq  out  1  |(edge_cap & irq_mask).

## Operation
- A write occurs on a rising clk edge when chipselect=1, write_n=0 and reset_n=1.
- Register map:
  - 0 DATA: read returns (sync_in & ~dir) | (data_out & dir); write loads data_out.
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns edge_cap; writing 1 to a bit clears that bit.
  - 4 OUTSET: data_out |= wdata; reads 0.
  - 5 OUTCLR: data_out &= ~wdata; reads 0.
  - 6, 7: reserved; read 0, writes ignored.
- Input path: in_port passes through SYNC_STAGES flops to form sync_in. One more flop holds prev. Edge for bit i:
  - rising: sync_in & ~prev
  - falling: ~sync_in & prev
  - any: sync_in ^ prev
- A detected edge sets edge_cap[i], which stays set until cleared by software.
- Edges are detected on all bits regardless of dir, so output lines can be looped back.
- Warm-up: after reset deasserts, a saturating counter suppresses edge detection for SYNC_STAGES+1 cycles. This prevents false captures from zeroed flops while the pins are high.
- Simultaneous edge detection and a write-1-to-clear on the same bit in the same cycle: the set wins, and the bit remains 1.
- A write to DATA, OUTSET or OUTCLR has no effect on edge_cap beyond the normal loopback path.
- Reset values (synchronous, while reset_n=0):
  - out_port = RESET_VALUE
  - out_en = DIR_RESET
  - irq_mask = 0, edge_cap = 0
  - synchroniser flops and prev = 0
  - warm-up counter = 0
  - irq = 0, readdata = 0-extended register value
- Reset asserted mid-operation clears all state on the next edge, including pending captures.

## Timing
- Write to DATA, DIR, OUTSET or OUTCLR: out_port / out_en change on the same clk edge that samples the write; visible from the next cycle.
- Read: readdata is valid in the same cycle as address and chipselect; there are no read side effects.
- in_port transition before edge N:
  - sync_in changes after edge N+SYNC_STAGES-1.
  - edge_cap and irq assert after edge N+SYNC_STAGES, a latency of SYNC_STAGES+1 cycles.
- Write-1-to-clear: edge_cap bit and irq drop after the write edge.
- Mask write: irq follows combinationally from the registered mask, one cycle after the write.

## Structure
- Package usb_pio_pkg holds:
  - register address constants ADDR_DATA..ADDR_OUTCLR
  - edge type constants EDGE_RISE, EDGE_FALL, EDGE_ANY
  - the data bus width constant 32
- Sub-module usb_pio_sync: WIDTH-wide SYNC_STAGES synchroniser, prev flop, warm-up counter and edge-detect output. The top level holds the register file, read mux and capture logic.

## Test plan
- Reset with RESET_VALUE=8'hA5, DIR_RESET=8'hFF -> out_port=A5, out_en=FF, irq=0, read addr3=0. Write DATA=3C -> out_port=3C after 1 edge.
- With out_port=3C: OUTSET 01 -> 3D; then OUTCLR 0C -> 31. A write to addr 6 leaves out_port at 31 and reads 0.
- DIR=0F, out_port=05, in_port=A0 held -> DATA read = A5 after SYNC_STAGES cycles, and not before.
- EDGE_TYPE=0, mask=02: pulse in_port[1] 0->1 -> edge_cap=02, irq=1 after exactly 3 cycles. A falling edge adds nothing. W1C 02 -> irq=0 next cycle.
- Rising edge detected in the same cycle as a W1C of that bit -> edge_cap bit stays 1, irq stays 1.
- in_port=FF held through reset release, EDGE_TYPE=2 -> edge_cap remains 0 after warm-up. Assert reset with captures pending -> all state cleared at the next edge.
